// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone period meter: state encoding, default width,
// and the absolute-difference helper used by the stability check and the target comparator.
package tone_pkg;

    localparam int TONE_WIDTH = 15;

    // Wide enough that WIDTH+1-bit operands never wrap for any WIDTH up to 31.
    localparam int DIFF_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        LOCK
    } tone_state_e;

    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchronizer for the asynchronous tone pin plus a previous-level flop;
// o_edge flags either polarity of transition, two clocks after capture.
module tone_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_edge
);

    logic r_s1, r_s2, r_s3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_edge  = r_s2 ^ r_s3;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the half-period of a square wave as half-period-1 clocks and locks on stable tones.
// Define TONE_MATCH_EN to add the target input and the registered tone_match output.
module tone_period_meter
    import tone_pkg::*;
#(
    parameter int WIDTH        = TONE_WIDTH,
    parameter int TIMEOUT      = 32767,
    parameter int TOL          = 4,
    parameter int STABLE_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tone_in,
`ifdef TONE_MATCH_EN
    input  logic [WIDTH-1:0] target,
    output logic             tone_match,
`endif
    output logic [WIDTH-1:0] period_value,
    output logic             period_valid,
    output logic             tone_present
);

    localparam int                SW         = $clog2(STABLE_COUNT + 1);
    localparam logic [WIDTH-1:0]  CNT_MAX    = WIDTH'(TIMEOUT);
    localparam logic [SW-1:0]     STABLE_TGT = SW'(STABLE_COUNT);
    localparam logic [DIFF_W-1:0] TOL_U      = DIFF_W'(TOL);

    tone_state_e      r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_prev_meas;
    logic [WIDTH-1:0] r_period_value;
    logic [SW-1:0]    r_stable;
    logic             r_prev_valid;
    logic             r_period_valid;
    logic             r_tone_present;

    logic             w_edge;
    logic             w_agree;
    logic             w_timeout;
    logic [SW-1:0]    w_stable_inc;

    tone_edge_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (tone_in),
        .o_level (),
        .o_edge  (w_edge)
    );

    // On an edge cycle r_cnt holds the just-finished measurement.
    assign w_agree      = r_prev_valid &&
                          (abs_diff(DIFF_W'(r_cnt), DIFF_W'(r_prev_meas)) <= TOL_U);
    assign w_timeout    = (r_cnt == CNT_MAX);
    assign w_stable_inc = r_stable + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_prev_meas    <= '0;
            r_period_value <= '0;
            r_stable       <= '0;
            r_prev_valid   <= 1'b0;
            r_period_valid <= 1'b0;
            r_tone_present <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (!enable) begin
                r_state        <= IDLE;
                r_cnt          <= '0;
                r_stable       <= '0;
                r_prev_valid   <= 1'b0;
                r_tone_present <= 1'b0;
            end else begin
                // NOTE: later non-blocking assignments in this block override this default count update.
                if (w_edge)
                    r_cnt <= '0;
                else if (!w_timeout)
                    r_cnt <= r_cnt + 1'b1;

                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (w_edge)
                            r_state <= ARM;
                    end
                    ARM: begin
                        if (w_edge) begin
                            r_prev_meas  <= r_cnt;
                            r_prev_valid <= 1'b1;
                            if (!w_agree) begin
                                r_stable <= '0;
                            end else begin
                                r_stable <= w_stable_inc;
                                if (w_stable_inc == STABLE_TGT) begin
                                    r_state        <= LOCK;
                                    r_period_value <= r_cnt;
                                    r_period_valid <= 1'b1;
                                    r_tone_present <= 1'b1;
                                end
                            end
                        end else if (w_timeout) begin
                            r_state      <= IDLE;
                            r_cnt        <= '0;
                            r_stable     <= '0;
                            r_prev_valid <= 1'b0;
                        end
                    end
                    LOCK: begin
                        if (w_edge) begin
                            r_prev_meas <= r_cnt;
                            if (w_agree) begin
                                r_period_value <= r_cnt;
                                r_period_valid <= 1'b1;
                            end else begin
                                r_state        <= ARM;
                                r_stable       <= '0;
                                r_tone_present <= 1'b0;
                            end
                        end else if (w_timeout) begin
                            r_state        <= IDLE;
                            r_cnt          <= '0;
                            r_stable       <= '0;
                            r_prev_valid   <= 1'b0;
                            r_tone_present <= 1'b0;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign period_value = r_period_value;
    assign period_valid = r_period_valid;
    assign tone_present = r_tone_present;

`ifdef TONE_MATCH_EN
    logic r_tone_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tone_match <= 1'b0;
        else
            r_tone_match <= enable && r_tone_present &&
                            (abs_diff(DIFF_W'(r_period_value), DIFF_W'(target)) <= TOL_U);
    end

    assign tone_match = r_tone_match;
`endif

endmodule
